// File: rtl/uart_serial_core.sv
// -----------------------------------------------------------------------------
// uart_serial_core
//
// Fixed-format UART engine: 8 data bits, no parity, 1 stop bit, LSB first.
// A programmable divider produces a 16x oversample tick. That tick drives
// independent TX and RX state machines. The block also emits a one-shot
// pulse on the first cycle after reset is released.
//
// Parameters
//   CLK_DIV_DEFAULT : reset value of the 16x divisor (tick period = div+1 clk)
//
// Ports
//   clk_i         in   clock, all logic on posedge
//   rst_i         in   asynchronous active-high reset
//   clkdiv_wr_i   in   load clkdiv_i into the divisor (also clears tick counter)
//   clkdiv_i      in   16-bit divisor value
//   tx_start_i    in   transmit request, accepted only while tx_busy_o==0
//   tx_data_i     in   byte to transmit, captured on acceptance
//   tx_busy_o     out  request pending or frame in progress
//   tx_done_o     out  1-cycle pulse at end of stop bit
//   stx_pad_o     out  serial TX line, idle high
//   srx_pad_i     in   serial RX line
//   rx_data_o     out  last received byte, held until next reception
//   rx_valid_o    out  1-cycle pulse when rx_data_o is newly valid
//   reset_done_o  out  1-cycle pulse after reset release
//
// Build option
//   UART_SERIAL_CORE_RX_SYNC_EN : when defined, srx_pad_i passes through a
//   2-flop synchronizer (reset value 1) before the RX FSM, adding 2 cycles
//   of RX latency. When undefined, srx_pad_i is sampled directly.
// -----------------------------------------------------------------------------
module uart_serial_core #(
    parameter logic [15:0] CLK_DIV_DEFAULT = 16'd27
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clkdiv_wr_i,
    input  logic [15:0] clkdiv_i,
    input  logic        tx_start_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_busy_o,
    output logic        tx_done_o,
    output logic        stx_pad_o,
    input  logic        srx_pad_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        reset_done_o
);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;

    logic [15:0] divisor;
    logic [15:0] tick_cnt;
    logic        tick;

    logic [1:0]  tx_state;
    logic        tx_pending;
    logic [3:0]  tx_tick_cnt;
    logic [2:0]  tx_bit_cnt;
    logic [7:0]  tx_shift;

    logic [1:0]  rx_state;
    logic [3:0]  rx_tick_cnt;
    logic [2:0]  rx_bit_cnt;
    logic [7:0]  rx_shift;
    logic        srx;

    logic        rst_seen;

    // ------------------------------------------------------------------
    // Reset-release notification: rst_seen is held high through reset and
    // is handed to reset_done_o on the first edge after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_seen     <= 1'b1;
            reset_done_o <= 1'b0;
        end else begin
            rst_seen     <= 1'b0;
            reset_done_o <= rst_seen;
        end
    end

    // ------------------------------------------------------------------
    // 16x oversample divider. The tick is combinational on the counter so
    // a divisor of 0 yields a tick on every cycle.
    // ------------------------------------------------------------------
    assign tick = (tick_cnt == divisor);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            divisor  <= CLK_DIV_DEFAULT;
            tick_cnt <= 16'd0;
        end else if (clkdiv_wr_i) begin
            divisor  <= clkdiv_i;
            tick_cnt <= 16'd0;
        end else if (tick) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Optional input synchronizer for the RX pad
    // ------------------------------------------------------------------
`ifdef UART_SERIAL_CORE_RX_SYNC_EN
    logic [1:0] srx_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            srx_sync <= 2'b11;
        end else begin
            srx_sync <= {srx_sync[0], srx_pad_i};
        end
    end

    assign srx = srx_sync[1];
`else
    assign srx = srx_pad_i;
`endif

    // ------------------------------------------------------------------
    // TX path. Busy covers both the accepted-but-not-started request and
    // the frame itself, so it falls on the same cycle as tx_done_o.
    // ------------------------------------------------------------------
    assign tx_busy_o = tx_pending | (tx_state != TX_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state    <= TX_IDLE;
            tx_pending  <= 1'b0;
            tx_tick_cnt <= 4'd0;
            tx_bit_cnt  <= 3'd0;
            stx_pad_o   <= 1'b1;
            tx_done_o   <= 1'b0;
        end else begin
            tx_done_o <= 1'b0;
            if (tx_start_i && !tx_busy_o) begin
                tx_pending <= 1'b1;
            end
            if (tick) begin
                case (tx_state)
                    TX_IDLE: begin
                        if (tx_pending) begin
                            tx_state    <= TX_START;
                            tx_pending  <= 1'b0;
                            tx_tick_cnt <= 4'd0;
                            stx_pad_o   <= 1'b0;
                        end
                    end
                    TX_START: begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        if (tx_tick_cnt == 4'd15) begin
                            tx_state   <= TX_DATA;
                            tx_bit_cnt <= 3'd0;
                            stx_pad_o  <= tx_shift[0];
                        end
                    end
                    TX_DATA: begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        if (tx_tick_cnt == 4'd15) begin
                            if (tx_bit_cnt == 3'd7) begin
                                tx_state  <= TX_STOP;
                                stx_pad_o <= 1'b1;
                            end else begin
                                tx_bit_cnt <= tx_bit_cnt + 3'd1;
                                // tx_shift moves right on this same edge,
                                // so bit [1] is the next bit to drive
                                stx_pad_o  <= tx_shift[1];
                            end
                        end
                    end
                    default: begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        if (tx_tick_cnt == 4'd15) begin
                            tx_state  <= TX_IDLE;
                            tx_done_o <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // TX data register: loaded on acceptance, shifted at each data-bit end
    always_ff @(posedge clk_i) begin
        if (tx_start_i && !tx_busy_o) begin
            tx_shift <= tx_data_i;
        end else if (tick && (tx_state == TX_DATA) && (tx_tick_cnt == 4'd15)) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // RX path. The stop bit is not checked: returning to IDLE after bit 7
    // lets the high stop level hold the FSM until the next start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state    <= RX_IDLE;
            rx_tick_cnt <= 4'd0;
            rx_bit_cnt  <= 3'd0;
            rx_data_o   <= 8'd0;
            rx_valid_o  <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (tick) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!srx) begin
                            rx_state    <= RX_START;
                            rx_tick_cnt <= 4'd0;
                            rx_bit_cnt  <= 3'd0;
                        end
                    end
                    RX_START: begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        if (rx_tick_cnt == 4'd15) begin
                            rx_state   <= RX_DATA;
                            rx_bit_cnt <= 3'd0;
                        end
                    end
                    default: begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        if (rx_tick_cnt == 4'd15) begin
                            if (rx_bit_cnt == 3'd7) begin
                                rx_state   <= RX_IDLE;
                                rx_data_o  <= rx_shift;
                                rx_valid_o <= 1'b1;
                            end else begin
                                rx_bit_cnt <= rx_bit_cnt + 3'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // RX shift register: sample on the 8th tick of each bit (mid-bit)
    always_ff @(posedge clk_i) begin
        if (tick && (rx_state == RX_DATA) && (rx_tick_cnt == 4'd7)) begin
            rx_shift <= {srx, rx_shift[7:1]};
        end
    end

endmodule

// File: tb/tb_uart_serial_core.sv
module tb_uart_serial_core;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clkdiv_wr_i = 1'b0;
    logic [15:0] clkdiv_i = 16'd0;
    logic        tx_start_i = 1'b0;
    logic [7:0]  tx_data_i = 8'd0;
    logic        tx_busy_o;
    logic        tx_done_o;
    logic        stx_pad_o;
    logic        srx_pad_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        reset_done_o;

    logic        loop_en = 1'b0;
    logic        srx_drv = 1'b1;

    assign srx_pad_i = loop_en ? stx_pad_o : srx_drv;

    always #5 clk_i = ~clk_i;

    uart_serial_core dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clkdiv_wr_i  (clkdiv_wr_i),
        .clkdiv_i     (clkdiv_i),
        .tx_start_i   (tx_start_i),
        .tx_data_i    (tx_data_i),
        .tx_busy_o    (tx_busy_o),
        .tx_done_o    (tx_done_o),
        .stx_pad_o    (stx_pad_o),
        .srx_pad_i    (srx_pad_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .reset_done_o (reset_done_o)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // event monitors
    int         done_cnt = 0;
    int         rxv_cnt  = 0;
    logic [7:0] rx_hist [0:15];

    always @(posedge clk_i) begin
        if (tx_done_o) done_cnt <= done_cnt + 1;
        if (rx_valid_o) begin
            rx_hist[rxv_cnt[3:0]] <= rx_data_o;
            rxv_cnt <= rxv_cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] div;
        logic [7:0]  tx;
        logic [7:0]  exp_rx;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_div(input logic [15:0] d);
        @(negedge clk_i);
        clkdiv_i    = d;
        clkdiv_wr_i = 1'b1;
        @(negedge clk_i);
        clkdiv_wr_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        while (tx_busy_o && k < 6000) begin
            @(negedge clk_i);
            k++;
        end
        check("send_idle", {31'd0, tx_busy_o}, 32'd0);
        tx_data_i  = b;
        tx_start_i = 1'b1;
        @(negedge clk_i);
        tx_start_i = 1'b0;
    endtask

    task automatic wait_rx(input string name, input int target, input int budget);
        int k = 0;
        while (rxv_cnt < target && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        check(name, rxv_cnt, target);
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        check(name, done_cnt, target);
    endtask

    initial begin
        int         r0;
        int         d0;
        int         done_k;
        int         w;
        logic [9:0] frame;

        vecs[0] = '{16'd0,  8'h7E, 8'h7E};
        vecs[1] = '{16'd1,  8'h01, 8'h01};
        vecs[2] = '{16'd2,  8'h80, 8'h80};
        vecs[3] = '{16'd3,  8'hC3, 8'hC3};
        vecs[4] = '{16'd5,  8'h96, 8'h96};
        vecs[5] = '{16'd27, 8'h5A, 8'h5A};

        // reset state
        repeat (3) @(negedge clk_i);
        check("rst_stx",        {31'd0, stx_pad_o},    32'd1);
        check("rst_busy",       {31'd0, tx_busy_o},    32'd0);
        check("rst_done",       {31'd0, tx_done_o},    32'd0);
        check("rst_valid",      {31'd0, rx_valid_o},   32'd0);
        check("rst_rxdata",     {24'd0, rx_data_o},    32'd0);
        check("rst_reset_done", {31'd0, reset_done_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_done_hi", {31'd0, reset_done_o}, 32'd1);
        @(negedge clk_i);
        check("reset_done_lo", {31'd0, reset_done_o}, 32'd0);
        check("post_rst_stx",  {31'd0, stx_pad_o},    32'd1);
        check("post_rst_busy", {31'd0, tx_busy_o},    32'd0);

        // TX waveform of 0xA5 at divisor 0
        set_div(16'd0);
        frame = {1'b1, 8'hA5, 1'b0};
        d0 = done_cnt;
        send(8'hA5);
        check("a5_busy", {31'd0, tx_busy_o}, 32'd1);
        w = 0;
        while (stx_pad_o && w < 10) begin
            @(negedge clk_i);
            w++;
        end
        check("a5_start_low", {31'd0, stx_pad_o}, 32'd0);
        done_k = -1;
        for (int k = 0; k < 200; k++) begin
            if (k < 160 && (k % 16 == 0 || k % 16 == 15))
                check("a5_stx", {31'd0, stx_pad_o}, {31'd0, frame[k / 16]});
            if (tx_done_o && done_k < 0) begin
                done_k = k;
                check("a5_busy_at_done", {31'd0, tx_busy_o}, 32'd0);
            end
            @(negedge clk_i);
        end
        check("a5_done_latency", done_k, 160);
        check("a5_done_count", done_cnt, d0 + 1);
        check("a5_idle_stx", {31'd0, stx_pad_o}, 32'd1);

        // RX of a driven 0x3C frame at divisor 0
        frame = {1'b1, 8'h3C, 1'b0};
        r0 = rxv_cnt;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 16; j++) begin
                srx_drv = frame[i];
                @(negedge clk_i);
            end
        end
        srx_drv = 1'b1;
        repeat (40) @(negedge clk_i);
        check("rx3c_count", rxv_cnt, r0 + 1);
        check("rx3c_data",  {24'd0, rx_hist[r0[3:0]]}, 32'h3C);
        check("rx3c_held",  {24'd0, rx_data_o}, 32'h3C);

        // table-driven loopback vectors
        loop_en = 1'b1;
        for (int v = 0; v < 6; v++) begin
            set_div(vecs[v].div);
            r0 = rxv_cnt;
            d0 = done_cnt;
            send(vecs[v].tx);
            wait_rx("vec_rx_count", r0 + 1, (int'(vecs[v].div) + 1) * 200);
            check("vec_rx_data", {24'd0, rx_hist[r0[3:0]]}, {24'd0, vecs[v].exp_rx});
            wait_done("vec_done", d0 + 1, (int'(vecs[v].div) + 1) * 60);
            check("vec_idle_stx", {31'd0, stx_pad_o}, 32'd1);
        end

        // back-to-back 0x00 then 0xFF in loopback at divisor 3
        set_div(16'd3);
        r0 = rxv_cnt;
        d0 = done_cnt;
        send(8'h00);
        send(8'hFF);
        wait_rx("b2b_rx_count", r0 + 2, 2000);
        check("b2b_rx0", {24'd0, rx_hist[r0[3:0]]}, 32'h00);
        check("b2b_rx1", {24'd0, rx_hist[(r0 + 1) % 16]}, 32'hFF);
        wait_done("b2b_done", d0 + 2, 400);

        // start while busy is ignored
        set_div(16'd0);
        r0 = rxv_cnt;
        d0 = done_cnt;
        send(8'h81);
        repeat (20) @(negedge clk_i);
        check("ign_busy", {31'd0, tx_busy_o}, 32'd1);
        tx_data_i  = 8'h55;
        tx_start_i = 1'b1;
        @(negedge clk_i);
        tx_start_i = 1'b0;
        repeat (400) @(negedge clk_i);
        check("ign_rx_count", rxv_cnt, r0 + 1);
        check("ign_rx_data",  {24'd0, rx_hist[r0[3:0]]}, 32'h81);
        check("ign_done",     done_cnt, d0 + 1);
        check("ign_busy_end", {31'd0, tx_busy_o}, 32'd0);

        // reset in the middle of a data bit
        loop_en = 1'b0;
        srx_drv = 1'b1;
        d0 = done_cnt;
        send(8'h00);
        repeat (50) @(negedge clk_i);
        check("mid_stx_low", {31'd0, stx_pad_o}, 32'd0);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_stx",  {31'd0, stx_pad_o}, 32'd1);
        check("mid_rst_busy", {31'd0, tx_busy_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_reset_done", {31'd0, reset_done_o}, 32'd1);
        repeat (200) @(negedge clk_i);
        check("mid_no_done", done_cnt, d0);
        check("mid_idle_stx", {31'd0, stx_pad_o}, 32'd1);

        // clean frame after the aborted one
        loop_en = 1'b1;
        set_div(16'd0);
        r0 = rxv_cnt;
        d0 = done_cnt;
        send(8'hA5);
        wait_rx("clean_rx_count", r0 + 1, 400);
        check("clean_rx_data", {24'd0, rx_hist[r0[3:0]]}, 32'hA5);
        wait_done("clean_done", d0 + 1, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
